// File: rtl/shl_arbiter.sv
// ============================================================================
//  Module   : shl_arbiter
//  Brief    : Round-robin arbiter sharing one registered shift-left unit
//             between M requesters; tags each issue and steers results back.
//             Optional macro SHL_ARB_PRIO_EN adds a PRIO input that restricts
//             arbitration to prioritised requesters when any are pending.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shl_arbiter #(
  parameter int N   = 16,
  parameter int M   = 4,
  parameter int LAT = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic [M-1:0]   REQ_VALID,
  input  logic [M*N-1:0] REQ_A,
  input  logic [M*N-1:0] REQ_B,
`ifdef SHL_ARB_PRIO_EN
  input  logic [M-1:0]   PRIO,
`endif
  output logic [M-1:0]   REQ_ACK,
  output logic           SH_EN,
  output logic           SH_R_IN1,
  output logic [N-1:0]   SH_D_IN1,
  output logic           SH_R_IN2,
  output logic [N-1:0]   SH_D_IN2,
  input  logic           SH_R_OUT,
  input  logic [N-1:0]   SH_D_OUT,
  output logic [M-1:0]   RES_VALID,
  output logic [N-1:0]   RES_DATA,
  output logic           ERR
);

  localparam int             c_PW  = (M > 1) ? $clog2(M) : 1;
  localparam logic [c_PW:0]  c_M_W = (c_PW+1)'(M);
  localparam logic [M-1:0]   c_ONE = {{(M-1){1'b0}}, 1'b1};

  logic [c_PW-1:0] r_ptr;
  logic            r_iss_v;
  logic [c_PW-1:0] r_iss_idx;
  logic [N-1:0]    r_d1;
  logic [N-1:0]    r_d2;
  logic [LAT-1:0]  r_tag_v;
  logic [c_PW-1:0] r_tag_idx [LAT];
  logic [M-1:0]    r_res_v;
  logic [N-1:0]    r_res_d;
  logic            r_err;

  logic [M-1:0]    w_elig;
  logic [2*M-1:0]  w_dbl;
  logic [M-1:0]    w_rot;
  logic            w_gnt_v;
  logic [c_PW-1:0] w_off;
  logic [c_PW:0]   w_sum;
  logic [c_PW-1:0] w_gnt_idx;
  logic [c_PW-1:0] w_ptr_nxt;
  logic [N-1:0]    w_sel_a;
  logic [N-1:0]    w_sel_b;
  logic            w_head_v;
  logic [M-1:0]    w_head_one;

`ifdef SHL_ARB_PRIO_EN
  assign w_elig = (|(REQ_VALID & PRIO)) ? (REQ_VALID & PRIO) : REQ_VALID;
`else
  assign w_elig = REQ_VALID;
`endif

  // Rotate so bit 0 is the requester at PTR, then pick the lowest set bit.
  assign w_dbl = {w_elig, w_elig};
  assign w_rot = M'(w_dbl >> r_ptr);

  always_comb begin
    w_gnt_v = 1'b0;
    w_off   = '0;
    for (int k = M-1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_gnt_v = 1'b1;
        w_off   = c_PW'(k);
      end
    end
    w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    w_gnt_idx = (w_sum >= c_M_W) ? c_PW'(w_sum - c_M_W) : c_PW'(w_sum);
    w_ptr_nxt = (w_gnt_idx == c_PW'(M-1)) ? '0 : w_gnt_idx + 1'b1;
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < M; k++) begin
      if (w_gnt_idx == c_PW'(k)) begin
        w_sel_a = REQ_A[k*N +: N];
        w_sel_b = REQ_B[k*N +: N];
      end
    end
  end

  assign REQ_ACK    = (EN && RST && w_gnt_v) ? (c_ONE << w_gnt_idx) : '0;
  assign w_head_v   = r_tag_v[LAT-1];
  assign w_head_one = c_ONE << r_tag_idx[LAT-1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ptr     <= '0;
      r_iss_v   <= 1'b0;
      r_iss_idx <= '0;
      r_d1      <= '0;
      r_d2      <= '0;
      r_tag_v   <= '0;
      for (int k = 0; k < LAT; k++) r_tag_idx[k] <= '0;
      r_res_v   <= '0;
      r_res_d   <= '0;
      r_err     <= 1'b0;
    end else if (EN) begin
      r_iss_v <= w_gnt_v;
      if (w_gnt_v) begin
        r_ptr     <= w_ptr_nxt;
        r_iss_idx <= w_gnt_idx;
        r_d1      <= w_sel_a;
        r_d2      <= w_sel_b;
      end
      // Tag pipe trails the issue register so its head lines up with SH_R_OUT.
      r_tag_v[0]   <= r_iss_v;
      r_tag_idx[0] <= r_iss_idx;
      for (int k = 1; k < LAT; k++) begin
        r_tag_v[k]   <= r_tag_v[k-1];
        r_tag_idx[k] <= r_tag_idx[k-1];
      end
      if (SH_R_OUT && w_head_v) begin
        r_res_v <= w_head_one;
        r_res_d <= SH_D_OUT;
      end else begin
        r_res_v <= '0;
      end
      if (SH_R_OUT && !w_head_v) r_err <= 1'b1;
    end
  end

  assign SH_EN     = EN;
  assign SH_R_IN1  = r_iss_v;
  assign SH_R_IN2  = r_iss_v;
  assign SH_D_IN1  = r_d1;
  assign SH_D_IN2  = r_d2;
  assign RES_VALID = r_res_v;
  assign RES_DATA  = r_res_d;
  assign ERR       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_shl_arbiter.sv
// ============================================================================
//  Module   : tb_shl_arbiter
//  Brief    : Self-checking bench for shl_arbiter with a behavioural shifter
//             and a queue-based scoreboard. Honours SHL_ARB_PRIO_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shl_arbiter;
  localparam int N   = 16;
  localparam int M   = 4;
  localparam int LAT = 1;

  logic           CLK = 1'b0;
  logic           RST;
  logic           EN;
  logic [M-1:0]   REQ_VALID;
  logic [M*N-1:0] REQ_A;
  logic [M*N-1:0] REQ_B;
  logic [M-1:0]   PRIO;
  logic [M-1:0]   REQ_ACK;
  logic           SH_EN, SH_R_IN1, SH_R_IN2, SH_R_OUT;
  logic [N-1:0]   SH_D_IN1, SH_D_IN2, SH_D_OUT;
  logic [M-1:0]   RES_VALID;
  logic [N-1:0]   RES_DATA;
  logic           ERR;
  logic           inj;

  always #5 CLK = ~CLK;

  shl_arbiter #(.N(N), .M(M), .LAT(LAT)) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .REQ_VALID(REQ_VALID), .REQ_A(REQ_A), .REQ_B(REQ_B),
`ifdef SHL_ARB_PRIO_EN
    .PRIO(PRIO),
`endif
    .REQ_ACK(REQ_ACK), .SH_EN(SH_EN),
    .SH_R_IN1(SH_R_IN1), .SH_D_IN1(SH_D_IN1),
    .SH_R_IN2(SH_R_IN2), .SH_D_IN2(SH_D_IN2),
    .SH_R_OUT(SH_R_OUT), .SH_D_OUT(SH_D_OUT),
    .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .ERR(ERR)
  );

  // Behavioural shared shifter with LAT enabled-cycle latency
  logic [LAT-1:0] sh_v;
  logic [N-1:0]   sh_d [LAT];
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh_v <= '0;
      for (int k = 0; k < LAT; k++) sh_d[k] <= '0;
    end else if (SH_EN) begin
      sh_v[0] <= SH_R_IN1 & SH_R_IN2;
      sh_d[0] <= SH_D_IN1 << SH_D_IN2;
      for (int k = 1; k < LAT; k++) begin
        sh_v[k] <= sh_v[k-1];
        sh_d[k] <= sh_d[k-1];
      end
    end
  end
  assign SH_R_OUT = sh_v[LAT-1] | inj;
  assign SH_D_OUT = inj ? 16'hBEEF : sh_d[LAT-1];

  // Reference model: expected results queued with the enabled-edge count at which they appear
  typedef struct {int due; int idx; logic [N-1:0] data;} res_t;
  res_t         m_q[$];
  int           m_ptr, m_edges, m_last_g;
  logic [M-1:0] m_res_v;
  logic [N-1:0] m_res_d, m_d1, m_d2;
  logic         m_iss_v, m_err;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [M-1:0] v, input logic [M-1:0] p);
    logic [M-1:0] e;
    e = ((v & p) != '0) ? (v & p) : v;
    for (int k = 0; k < M; k++)
      if (e[(m_ptr + k) % M]) return (m_ptr + k) % M;
    return -1;
  endfunction

  function automatic logic [N-1:0] shl(input logic [N-1:0] a, input logic [N-1:0] b);
    return (b >= N) ? '0 : (a << b);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ptr = 0; m_last_g = -1;
    m_res_v = '0; m_res_d = '0; m_d1 = '0; m_d2 = '0;
    m_iss_v = 1'b0; m_err = 1'b0;
  endtask

  task automatic check_outputs(input logic [M-1:0] exp_ack, input bit en);
    check("ack", REQ_ACK, exp_ack);
    check("res_valid", RES_VALID, m_res_v);
    check("res_data", RES_DATA, m_res_d);
    check("err", ERR, m_err);
    check("sh_en", SH_EN, en);
    check("iss_v1", SH_R_IN1, m_iss_v);
    check("iss_v2", SH_R_IN2, m_iss_v);
    check("iss_d1", SH_D_IN1, m_d1);
    check("iss_d2", SH_D_IN2, m_d2);
  endtask

  task automatic cycle(input bit en, input logic [M-1:0] v,
                       input logic [M*N-1:0] a, input logic [M*N-1:0] b, input bit inj_i);
    int g;
    bit popped;
    logic [M-1:0] p;
    @(negedge CLK);
    EN = en; REQ_VALID = v; REQ_A = a; REQ_B = b; inj = inj_i;
    #1;
`ifdef SHL_ARB_PRIO_EN
    p = PRIO;
`else
    p = '0;
`endif
    g = en ? model_grant(v, p) : -1;
    check_outputs((g >= 0) ? (M'(1) << g) : '0, en);
    m_last_g = g;
    if (en) begin
      popped = 1'b0;
      if (g >= 0) m_q.push_back('{due: m_edges + 2 + LAT, idx: g, data: shl(a[g*N +: N], b[g*N +: N])});
      m_edges++;
      if (m_q.size() > 0 && m_q[0].due == m_edges) begin
        m_res_v = M'(1) << m_q[0].idx;
        m_res_d = m_q[0].data;
        void'(m_q.pop_front());
        popped = 1'b1;
      end else begin
        m_res_v = '0;
      end
      if (inj_i && !popped) m_err = 1'b1;
      m_iss_v = (g >= 0);
      if (g >= 0) begin
        m_d1 = a[g*N +: N];
        m_d2 = b[g*N +: N];
        m_ptr = (g + 1) % M;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, '0, '0, '0, 1'b0);
  endtask

  task automatic reset_mid_stream();
    @(negedge CLK);
    RST = 1'b0; inj = 1'b1; EN = 1'b1; REQ_VALID = '0;
    #1;
    model_reset();
    check_outputs('0, 1'b1);
    @(negedge CLK);
    #1;
    check_outputs('0, 1'b1);
    RST = 1'b1; inj = 1'b0;
  endtask

  logic [M-1:0]   rv;
  logic [M*N-1:0] ra, rb;

  initial begin
    RST = 1'b0; EN = 1'b0; REQ_VALID = '0; REQ_A = '0; REQ_B = '0; PRIO = '0; inj = 1'b0;
    m_edges = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    idle(2);
    cycle(1'b1, 4'b0011, {16'h0, 16'h0, 16'h0007, 16'h0005}, {16'h0, 16'h0, 16'h0002, 16'h0001}, 1'b0);

    // Reset with traffic in flight, then single request A=3, B=4
    reset_mid_stream();
    cycle(1'b1, 4'b0001, {48'h0, 16'h0003}, {48'h0, 16'h0004}, 1'b0);
    idle(4);

    // All four requesters continuously valid
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 4'b1111, {16'h0009, 16'h0101, 16'h8001, 16'h00FF},
            {16'h0003, 16'h0008, 16'h0001, 16'h0004}, 1'b0);
    idle(4);

    // Drive PTR to 3 via requester 2, grant 2 again, then 0 and 3 contend
    cycle(1'b1, 4'b0100, {16'h0, 16'h0011, 32'h0}, {16'h0, 16'h0001, 32'h0}, 1'b0);
    cycle(1'b1, 4'b0100, {16'h0, 16'h0012, 32'h0}, {16'h0, 16'h0002, 32'h0}, 1'b0);
    cycle(1'b1, 4'b1001, {16'h0033, 32'h0, 16'h0030}, {16'h0003, 32'h0, 16'h0001}, 1'b0);
    cycle(1'b1, 4'b0001, {48'h0, 16'h0030}, {48'h0, 16'h0001}, 1'b0);
    idle(4);

    // Two in flight, then EN=0 for two cycles
    cycle(1'b1, 4'b0001, {48'h0, 16'h00A1}, {48'h0, 16'h0002}, 1'b0);
    cycle(1'b1, 4'b0010, {32'h0, 16'h00B2, 16'h0}, {32'h0, 16'h0003, 16'h0}, 1'b0);
    cycle(1'b0, 4'b0000, '0, '0, 1'b0);
    cycle(1'b0, 4'b0000, '0, '0, 1'b0);
    idle(5);

    // Orphan result sets sticky ERR; shift amount equal to N yields zero
    cycle(1'b1, '0, '0, '0, 1'b1);
    idle(2);
    cycle(1'b1, 4'b0010, {32'h0, 16'hFFFF, 16'h0}, {32'h0, 16'h0010, 16'h0}, 1'b0);
    idle(4);

`ifdef SHL_ARB_PRIO_EN
    PRIO = 4'b0100;
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 4'b0101, {16'h0, 16'h0021, 16'h0, 16'h0044}, {16'h0, 16'h0001, 16'h0, 16'h0002}, 1'b0);
    PRIO = '0;
    cycle(1'b1, 4'b0101, {16'h0, 16'h0021, 16'h0, 16'h0044}, {16'h0, 16'h0001, 16'h0, 16'h0002}, 1'b0);
    idle(4);
`endif

    // Randomised traffic honouring the hold-until-ACK obligation
    rv = '0; ra = '0; rb = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < M; i++) begin
        if (!rv[i] || m_last_g == i) begin
          rv[i] = ($urandom_range(0, 9) < 6);
          ra[i*N +: N] = N'($urandom);
          rb[i*N +: N] = N'($urandom_range(0, 17));
        end else if ($urandom_range(0, 9) == 0) begin
          rv[i] = 1'b0;
        end
      end
`ifdef SHL_ARB_PRIO_EN
      PRIO = M'($urandom);
`endif
      cycle($urandom_range(0, 9) != 0, rv, ra, rb, 1'b0);
    end
    idle(6);
    check("queue_drained", 64'(m_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
